// File: rtl/scan_pkg.sv
// Shared types, constants and decode helper for the scan decoder slice.
package scan_pkg;

    // Largest channel count the decode helper can produce.
    localparam int MAX_CH = 64;

    // Encoding of the mode input.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Controller states: outputs parked, showing a channel, or dead-time.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } scan_state_e;

    // One-hot decode of idx over n_ch lines at the requested polarity.
    // Lines at and above n_ch are returned as 0; callers size-cast to N_CH.
    function automatic logic [MAX_CH-1:0] onehot_decode(
        input logic [31:0] idx,
        input int          n_ch,
        input logic        active_low
    );
        logic [MAX_CH-1:0] lines;
        lines = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n_ch) begin
                lines[i] = ((32'(i) == idx) != active_low);
            end
        end
        return lines;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell prescaler: counts 0..div while enabled and flags the terminal count.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] count;

    // A count already past div (div lowered mid-dwell) also terminates, so a
    // shrinking divide never forces a long wrap through the full counter range.
    assign tc = enable && !clear && (count >= div);

    // Counter register: clear has priority, terminal count restarts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N_CH select-line driver with manual/auto-scan and blanking.
module scan_decoder
    import scan_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int N_CH       = 4,
    parameter int DIV_W      = 16,
    parameter int BLANK_CYC  = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [DIV_W-1:0] div,
    output logic [N_CH-1:0]  y,
    output logic [SEL_W-1:0] idx,
    output logic             tick,
    output logic             wrap
);

    localparam int               BLANK_W      = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
    localparam int               BLANK_LAST   = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic [BLANK_W-1:0] BLANK_LAST_V = BLANK_W'(BLANK_LAST);
    localparam logic [SEL_W-1:0] LAST_IDX     = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_V       = (SEL_W + 1)'(N_CH);
    localparam logic [N_CH-1:0]  Y_IDLE       = {N_CH{ACTIVE_LOW}};
    localparam bit               HAS_BLANK    = (BLANK_CYC > 0);

    // Reject configurations where idx could not address every channel.
    generate
        if (N_CH < 2 || N_CH > (1 << SEL_W) || N_CH > MAX_CH || BLANK_CYC < 0 || DIV_W < 1) begin : g_bad_cfg
            $error("scan_decoder: illegal parameters (need 2 <= N_CH <= 2**SEL_W, BLANK_CYC >= 0)");
        end
    endgenerate

    scan_state_e         state;
    scan_state_e         state_next;
    logic [SEL_W-1:0]    idx_next;
    logic [BLANK_W-1:0]  blank_cnt;
    logic [BLANK_W-1:0]  blank_next;
    logic [N_CH-1:0]     y_next;
    logic                tick_next;
    logic                wrap_next;
    logic                sel_valid;
    logic                presc_run;
    logic                presc_tc;
    logic                show;

    assign sel_valid = ({1'b0, sel_in} < N_CH_V);

    // The prescaler only advances while a channel is being shown in auto mode;
    // any other situation holds it at zero so every dwell starts fresh.
    assign presc_run = en && (state == ACTIVE) && (mode == MODE_AUTO);

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!presc_run),
        .enable (presc_run),
        .div    (div),
        .tc     (presc_tc)
    );

    // Next-state, next-index and next-output logic; y is computed from the
    // values that will be registered so it moves together with state and idx.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        blank_next = '0;
        wrap_next  = 1'b0;

        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ACTIVE;
                    if (mode == MODE_MANUAL && sel_valid) begin
                        idx_next = sel_in;
                    end
                end
                ACTIVE: begin
                    if (mode == MODE_AUTO) begin
                        if (presc_tc) begin
                            idx_next   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                            wrap_next  = (idx == LAST_IDX);
                            state_next = HAS_BLANK ? BLANK : ACTIVE;
                        end
                    end else if (sel_valid && (sel_in != idx)) begin
                        idx_next   = sel_in;
                        state_next = HAS_BLANK ? BLANK : ACTIVE;
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST_V) begin
                        state_next = ACTIVE;
                    end else begin
                        blank_next = blank_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        tick_next = (idx_next != idx);
        show      = (state_next == ACTIVE) && !((mode == MODE_MANUAL) && !sel_valid);
        y_next    = show ? N_CH'(onehot_decode(32'(idx_next), N_CH, ACTIVE_LOW)) : Y_IDLE;
    end

    // State and output registers; reset parks every line at the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            blank_cnt <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            y         <= Y_IDLE;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            blank_cnt <= blank_next;
            tick      <= tick_next;
            wrap      <= wrap_next;
            y         <= y_next;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench: four parameterisations driven in lockstep and compared
// every cycle against a counter-based behavioural model of the scan rules.
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  sel_in;
    logic [15:0] div;

    logic [3:0] y0;
    logic [3:0] y1;
    logic [4:0] y2;
    logic [7:0] y3;
    logic [1:0] idx0;
    logic [1:0] idx1;
    logic [2:0] idx2;
    logic [2:0] idx3;
    logic       tick0, tick1, tick2, tick3;
    logic       wrap0, wrap1, wrap2, wrap3;

    int checks = 0;
    int errors = 0;

    // Per-instance configuration: channels, blank cycles, polarity, select width.
    int p_n[4]  = '{4, 4, 5, 8};
    int p_b[4]  = '{1, 0, 2, 1};
    int p_al[4] = '{1, 1, 1, 0};
    int p_sw[4] = '{2, 2, 3, 3};

    // Model state: running flag, blank cycles still owed, cycles dwelt so far.
    bit m_run[4];
    int m_blank[4];
    int m_dwell[4];
    int m_idx[4];
    bit m_tick[4];
    bit m_wrap[4];
    int m_y[4];

    scan_decoder #(.SEL_W(2), .N_CH(4), .DIV_W(16), .BLANK_CYC(1), .ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in[1:0]), .div(div),
        .y(y0), .idx(idx0), .tick(tick0), .wrap(wrap0));

    scan_decoder #(.SEL_W(2), .N_CH(4), .DIV_W(16), .BLANK_CYC(0), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in[1:0]), .div(div),
        .y(y1), .idx(idx1), .tick(tick1), .wrap(wrap1));

    scan_decoder #(.SEL_W(3), .N_CH(5), .DIV_W(16), .BLANK_CYC(2), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .div(div),
        .y(y2), .idx(idx2), .tick(tick2), .wrap(wrap2));

    scan_decoder #(.SEL_W(3), .N_CH(8), .DIV_W(16), .BLANK_CYC(1), .ACTIVE_LOW(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .div(div),
        .y(y3), .idx(idx3), .tick(tick3), .wrap(wrap3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int inactive_lines(input int k);
        return (p_al[k] != 0) ? ((1 << p_n[k]) - 1) : 0;
    endfunction

    function automatic int shown_lines(input int k, input int ch);
        int mask;
        mask = (1 << p_n[k]) - 1;
        return (p_al[k] != 0) ? (mask & ~(1 << ch)) : (1 << ch);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_run[k]   = 1'b0;
            m_blank[k] = 0;
            m_dwell[k] = 0;
            m_idx[k]   = 0;
            m_tick[k]  = 1'b0;
            m_wrap[k]  = 1'b0;
            m_y[k]     = inactive_lines(k);
        end
    endtask

    // One clock edge of the scan rules, using the inputs sampled at that edge.
    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int s;
            int nxt;
            bit ok;
            s   = int'(sel_in) & ((1 << p_sw[k]) - 1);
            ok  = (s < p_n[k]);
            nxt = m_idx[k];
            m_wrap[k] = 1'b0;
            if (!en) begin
                m_run[k]   = 1'b0;
                m_blank[k] = 0;
                m_dwell[k] = 0;
            end else if (!m_run[k]) begin
                m_run[k]   = 1'b1;
                m_dwell[k] = 0;
                if (!mode && ok) nxt = s;
            end else if (m_blank[k] > 0) begin
                m_blank[k] = m_blank[k] - 1;
                m_dwell[k] = 0;
            end else if (mode) begin
                if (m_dwell[k] >= int'(div)) begin
                    nxt        = (m_idx[k] + 1) % p_n[k];
                    m_wrap[k]  = (nxt == 0);
                    m_dwell[k] = 0;
                    m_blank[k] = p_b[k];
                end else begin
                    m_dwell[k] = m_dwell[k] + 1;
                end
            end else begin
                m_dwell[k] = 0;
                if (ok && s != m_idx[k]) begin
                    nxt        = s;
                    m_blank[k] = p_b[k];
                end
            end
            m_tick[k] = (nxt != m_idx[k]);
            m_idx[k]  = nxt;
            if (m_run[k] && m_blank[k] == 0 && (mode || ok)) begin
                m_y[k] = shown_lines(k, m_idx[k]);
            end else begin
                m_y[k] = inactive_lines(k);
            end
        end
    endtask

    task automatic check_output(input string tag);
        logic [7:0] oy[4];
        logic [7:0] oi[4];
        logic       ot[4];
        logic       ow[4];
        oy[0] = {4'b0, y0};   oy[1] = {4'b0, y1};   oy[2] = {3'b0, y2};   oy[3] = y3;
        oi[0] = {6'b0, idx0}; oi[1] = {6'b0, idx1}; oi[2] = {5'b0, idx2}; oi[3] = {5'b0, idx3};
        ot[0] = tick0; ot[1] = tick1; ot[2] = tick2; ot[3] = tick3;
        ow[0] = wrap0; ow[1] = wrap1; ow[2] = wrap2; ow[3] = wrap3;
        for (int k = 0; k < 4; k++) begin
            checks++;
            assert (oy[k] === 8'(m_y[k])) else begin
                errors++;
                $error("[TB] FAIL %s inst%0d y observed=%b expected=%b", tag, k, oy[k], 8'(m_y[k]));
            end
            checks++;
            assert (oi[k] === 8'(m_idx[k])) else begin
                errors++;
                $error("[TB] FAIL %s inst%0d idx observed=%0d expected=%0d", tag, k, oi[k], m_idx[k]);
            end
            checks++;
            assert (ot[k] === m_tick[k]) else begin
                errors++;
                $error("[TB] FAIL %s inst%0d tick observed=%b expected=%b", tag, k, ot[k], m_tick[k]);
            end
            checks++;
            assert (ow[k] === m_wrap[k]) else begin
                errors++;
                $error("[TB] FAIL %s inst%0d wrap observed=%b expected=%b", tag, k, ow[k], m_wrap[k]);
            end
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic m, input logic [2:0] s, input logic [15:0] d);
        en     = e;
        mode   = m;
        sel_in = s;
        div    = d;
    endtask

    task automatic run_cycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check_output(tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b1, 1'b1, 3'd0, 16'd2);
        model_reset();
        run_cycles(2, "reset");

        // Release into auto scan, dwell of three cycles.
        rst_n = 1'b1;
        run_cycles(9, "enable_auto");

        // Fastest scan: advance every cycle, wrap once per frame.
        apply_stimulus(1'b0, 1'b1, 3'd0, 16'd0);
        run_cycles(1, "idle_div0");
        apply_stimulus(1'b1, 1'b1, 3'd0, 16'd0);
        run_cycles(12, "frame_wrap");

        // Manual select 0 then 2, then hold.
        apply_stimulus(1'b1, 1'b0, 3'd0, 16'd0);
        run_cycles(4, "manual_sel0");
        apply_stimulus(1'b1, 1'b0, 3'd2, 16'd0);
        run_cycles(4, "manual_sel2");
        run_cycles(3, "manual_hold");

        // Out-of-range select on the five-channel instance, then a legal one.
        apply_stimulus(1'b1, 1'b0, 3'd6, 16'd0);
        run_cycles(3, "invalid_sel");
        apply_stimulus(1'b1, 1'b0, 3'd4, 16'd0);
        run_cycles(4, "sel_after_invalid");

        // Auto with div=1, disable mid-scan, re-enable, then async reset.
        apply_stimulus(1'b0, 1'b1, 3'd4, 16'd1);
        run_cycles(1, "idle_div1");
        apply_stimulus(1'b1, 1'b1, 3'd4, 16'd1);
        run_cycles(8, "auto_div1");
        apply_stimulus(1'b0, 1'b1, 3'd4, 16'd1);
        run_cycles(3, "disable");
        apply_stimulus(1'b1, 1'b1, 3'd4, 16'd1);
        run_cycles(5, "reenable");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("async_reset");
        run_cycles(2, "reset_hold");
        rst_n = 1'b1;
        run_cycles(30, "frame_div1");

        // Randomised traffic; div only changes while disabled.
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                en = ~en;
                if (!en) div = 16'($urandom_range(0, 3));
            end else if (r < 10) begin
                mode = ~mode;
            end else if (r < 30) begin
                sel_in = 3'($urandom_range(0, 7));
            end
            run_cycles(1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
